frame_pixel_sender: RTL and testbench

Raster-order pixel transmitter that feeds the convolution image loader. It accepts a grayscale pixel stream from upstream (camera or ROM source) over a valid/ready handshake. For each pixel it drives the row/column address pair, the pixel value and a write strobe, walking one full frame of `Image_height` × `Image_width` pixels per `start` request. It also signals frame completion and flags framing errors.

---
 rtl/frame_stream_pkg.sv | 26 ++
 rtl/frame_pixel_sender_rgb_to_gray.sv | 38 +++
 rtl/frame_pixel_sender.sv | 197 +++++++++++++++++++
 tb/tb_frame_pixel_sender.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_stream_pkg.sv
// -----------------------------------------------------------------------------
// frame_stream_pkg
// Shared types and constants for the frame pixel sender.
//   fps_state_t            : sender FSM state (IDLE, STREAM, DONE)
//   FPS_ST_*               : raw encodings backing the enum
//   GRAY_COEF_R/G/B        : luma weights (sum to 256) for RGB->gray
// Optional feature macro used by the consumers: FRAME_PIXEL_SENDER_RGB_IN_EN
// -----------------------------------------------------------------------------
package frame_stream_pkg;

    localparam logic [1:0] FPS_ST_IDLE   = 2'd0;
    localparam logic [1:0] FPS_ST_STREAM = 2'd1;
    localparam logic [1:0] FPS_ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = FPS_ST_IDLE,
        STREAM = FPS_ST_STREAM,
        DONE   = FPS_ST_DONE
    } fps_state_t;

    // Weights sum to 256 so that white maps exactly to full scale after >> 8.
    localparam logic [7:0] GRAY_COEF_R = 8'd77;
    localparam logic [7:0] GRAY_COEF_G = 8'd150;
    localparam logic [7:0] GRAY_COEF_B = 8'd29;

endpackage : frame_stream_pkg

// File: rtl/frame_pixel_sender_rgb_to_gray.sv
// -----------------------------------------------------------------------------
// rgb_to_gray
// Purely combinational RGB -> grayscale converter.
//   gray = (77*R + 150*G + 29*B) >> 8, evaluated in COLDepth+8 bits.
// Ports:
//   rgb  in  3*COLDepth : packed {R,G,B}, R in the MSBs
//   gray out COLDepth   : luma value
// Used by frame_pixel_sender only when FRAME_PIXEL_SENDER_RGB_IN_EN is defined.
// -----------------------------------------------------------------------------
module rgb_to_gray
    import frame_stream_pkg::*;
#(
    parameter int COLDepth = 8
)
(
    input  logic [3*COLDepth-1:0] rgb,
    output logic [COLDepth-1:0]   gray
);

    localparam int SUM_W = COLDepth + 8;

    logic [SUM_W-1:0] r_s;
    logic [SUM_W-1:0] g_s;
    logic [SUM_W-1:0] b_s;
    logic [SUM_W-1:0] sum_s;

    assign r_s = SUM_W'(rgb[3*COLDepth-1 -: COLDepth]);
    assign g_s = SUM_W'(rgb[2*COLDepth-1 -: COLDepth]);
    assign b_s = SUM_W'(rgb[COLDepth-1 -: COLDepth]);

    // The weighted sum never exceeds 256*(2^COLDepth-1), so SUM_W bits suffice.
    assign sum_s = (r_s * SUM_W'(GRAY_COEF_R))
                 + (g_s * SUM_W'(GRAY_COEF_G))
                 + (b_s * SUM_W'(GRAY_COEF_B));

    assign gray = sum_s[SUM_W-1:8];

endmodule : rgb_to_gray

// File: rtl/frame_pixel_sender.sv
// -----------------------------------------------------------------------------
// frame_pixel_sender
// Raster-order pixel transmitter feeding the convolution image loader.
// Per start request it accepts Image_height x Image_width pixels over a
// valid/ready handshake and emits each one with its row/column address and a
// write strobe one cycle after the accept.
//
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   start              : one-cycle frame request, honoured only in IDLE
//   s_valid/s_ready    : upstream handshake (s_ready == state is STREAM)
//   s_pixel            : COLDepth gray, or 3*COLDepth {R,G,B} with the macro
//   s_last             : upstream end-of-frame marker (checked, not obeyed)
//   addr_x / addr_y    : row / column of the written pixel
//   pixel_out, pixel_we: pixel value and its write strobe
//   busy               : high in STREAM and DONE
//   frame_done         : pulse alongside the write of the final pixel
//   sync_err           : sticky s_last mismatch flag, cleared by start
//
// Optional feature: define FRAME_PIXEL_SENDER_RGB_IN_EN to take RGB input and
// convert it to gray ahead of the output register.
// -----------------------------------------------------------------------------
module frame_pixel_sender
    import frame_stream_pkg::*;
#(
    parameter int COLDepth     = 8,
    parameter int Image_height = 20,
    parameter int Image_width  = 20,
    parameter int ADDR_W       = 5
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  s_valid,
`ifdef FRAME_PIXEL_SENDER_RGB_IN_EN
    input  logic [3*COLDepth-1:0] s_pixel,
`else
    input  logic [COLDepth-1:0]   s_pixel,
`endif
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [ADDR_W-1:0]     addr_x,
    output logic [ADDR_W-1:0]     addr_y,
    output logic [COLDepth-1:0]   pixel_out,
    output logic                  pixel_we,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  sync_err
);

    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(Image_height - 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(Image_width - 1);

    fps_state_t            state_q;
    fps_state_t            state_d;
    logic [ADDR_W-1:0]     row_q;
    logic [ADDR_W-1:0]     row_d;
    logic [ADDR_W-1:0]     col_q;
    logic [ADDR_W-1:0]     col_d;
    logic [ADDR_W-1:0]     addr_x_q;
    logic [ADDR_W-1:0]     addr_x_d;
    logic [ADDR_W-1:0]     addr_y_q;
    logic [ADDR_W-1:0]     addr_y_d;
    logic [COLDepth-1:0]   pixel_out_q;
    logic [COLDepth-1:0]   pixel_out_d;
    logic                  pixel_we_q;
    logic                  pixel_we_d;
    logic                  frame_done_q;
    logic                  frame_done_d;
    logic                  sync_err_q;
    logic                  sync_err_d;

    logic                  stream_s;
    logic                  accept_s;
    logic                  at_last_s;
    logic [COLDepth-1:0]   gray_s;

`ifdef FRAME_PIXEL_SENDER_RGB_IN_EN
    rgb_to_gray #(
        .COLDepth (COLDepth)
    ) u_rgb_to_gray (
        .rgb  (s_pixel),
        .gray (gray_s)
    );
`else
    assign gray_s = s_pixel;
`endif

    // Ready depends on the state register alone, never on s_valid.
    assign stream_s  = (state_q == STREAM);
    assign accept_s  = s_valid && stream_s;
    assign at_last_s = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Next-state, raster counters and output register inputs.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        addr_x_d     = addr_x_q;
        addr_y_d     = addr_y_q;
        pixel_out_d  = pixel_out_q;
        pixel_we_d   = 1'b0;
        frame_done_d = 1'b0;
        sync_err_d   = sync_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = STREAM;
                    row_d      = {ADDR_W{1'b0}};
                    col_d      = {ADDR_W{1'b0}};
                    sync_err_d = 1'b0;
                end else begin
                    state_d    = IDLE;
                end
            end

            STREAM: begin
                if (accept_s) begin
                    addr_x_d    = row_q;
                    addr_y_d    = col_q;
                    pixel_out_d = gray_s;
                    pixel_we_d  = 1'b1;

                    // s_last must coincide exactly with the final position.
                    if (s_last != at_last_s) begin
                        sync_err_d = 1'b1;
                    end else begin
                        sync_err_d = sync_err_q;
                    end

                    // The frame ends by count only; s_last does not steer it.
                    if (at_last_s) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                        row_d        = {ADDR_W{1'b0}};
                        col_d        = {ADDR_W{1'b0}};
                    end else if (col_q == COL_LAST) begin
                        col_d = {ADDR_W{1'b0}};
                        row_d = row_q + ADDR_W'(1);
                    end else begin
                        col_d = col_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = STREAM;
                end
            end

            DONE: begin
                // start here is dropped, not remembered.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                row_d   = {ADDR_W{1'b0}};
                col_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            row_q        <= {ADDR_W{1'b0}};
            col_q        <= {ADDR_W{1'b0}};
            addr_x_q     <= {ADDR_W{1'b0}};
            addr_y_q     <= {ADDR_W{1'b0}};
            pixel_out_q  <= {COLDepth{1'b0}};
            pixel_we_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            addr_x_q     <= addr_x_d;
            addr_y_q     <= addr_y_d;
            pixel_out_q  <= pixel_out_d;
            pixel_we_q   <= pixel_we_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign s_ready    = stream_s;
    assign busy       = (state_q != IDLE);
    assign addr_x     = addr_x_q;
    assign addr_y     = addr_y_q;
    assign pixel_out  = pixel_out_q;
    assign pixel_we   = pixel_we_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule : frame_pixel_sender

// File: tb/tb_frame_pixel_sender.sv
// -----------------------------------------------------------------------------
// tb_frame_pixel_sender
// Scoreboard bench: every accepted pixel pushes its expected write (address,
// value, frame_done, sync_err) and a negedge monitor pops and compares each
// pixel_we cycle. Scenario tasks add their own inline checks.
// -----------------------------------------------------------------------------
module tb_frame_pixel_sender;

    localparam int COLD  = 8;
    localparam int IMG_H = 20;
    localparam int IMG_W = 20;
    localparam int AW    = 5;
    localparam int NPIX  = IMG_H * IMG_W;
`ifdef FRAME_PIXEL_SENDER_RGB_IN_EN
    localparam int PIN_W = 3 * COLD;
`else
    localparam int PIN_W = COLD;
`endif

    typedef struct packed {
        logic [AW-1:0]   x;
        logic [AW-1:0]   y;
        logic [COLD-1:0] pix;
        logic            done;
        logic            sync;
    } sb_t;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             s_valid;
    logic [PIN_W-1:0] s_pixel;
    logic             s_last;
    logic             s_ready;
    logic [AW-1:0]    addr_x;
    logic [AW-1:0]    addr_y;
    logic [COLD-1:0]  pixel_out;
    logic             pixel_we;
    logic             busy;
    logic             frame_done;
    logic             sync_err;

    int  vectors     = 0;
    int  miscompares = 0;
    int  writes_seen = 0;
    sb_t sb_q[$];
    logic exp_sync;

    frame_pixel_sender #(
        .COLDepth     (COLD),
        .Image_height (IMG_H),
        .Image_width  (IMG_W),
        .ADDR_W       (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_pixel    (s_pixel),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .addr_x     (addr_x),
        .addr_y     (addr_y),
        .pixel_out  (pixel_out),
        .pixel_we   (pixel_we),
        .busy       (busy),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Stimulus pixel for index k of a frame tagged with seed.
    function automatic logic [PIN_W-1:0] stim_pix(input int k, input int seed);
        logic [COLD-1:0] p;
        p = COLD'((k * 7 + seed) % 256);
`ifdef FRAME_PIXEL_SENDER_RGB_IN_EN
        if (seed == 99 && k == 0) return 24'hFFFFFF;
        if (seed == 99 && k == 1) return 24'hFF0000;
        if (seed == 99 && k == 2) return 24'h0000FF;
        return {p, p, p};
`else
        return p;
`endif
    endfunction

    // Expected gray value for the same index; {p,p,p} converts back to p.
    function automatic logic [COLD-1:0] exp_pix(input int k, input int seed);
`ifdef FRAME_PIXEL_SENDER_RGB_IN_EN
        if (seed == 99 && k == 0) return 8'd255;
        if (seed == 99 && k == 1) return 8'd76;
        if (seed == 99 && k == 2) return 8'd28;
`endif
        return COLD'((k * 7 + seed) % 256);
    endfunction

    // Scoreboard monitor: one comparison per sampled cycle.
    always @(negedge clk) begin
        sb_t e;
        logic [AW+AW+COLD+2:0] obs;
        logic [AW+AW+COLD+2:0] expv;
        if (pixel_we === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got write at (%0d,%0d) pix %0d, required no write",
                         addr_x, addr_y, pixel_out);
            end else begin
                e = sb_q.pop_front();
                writes_seen++;
                obs  = {addr_x, addr_y, pixel_out, frame_done, sync_err, busy};
                expv = {e.x, e.y, e.pix, e.done, e.sync, 1'b1};
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL write: got x=%0d y=%0d pix=%0d done=%0b err=%0b busy=%0b, required x=%0d y=%0d pix=%0d done=%0b err=%0b busy=1",
                             addr_x, addr_y, pixel_out, frame_done, sync_err, busy,
                             e.x, e.y, e.pix, e.done, e.sync);
                end
            end
        end else if (reset_n === 1'b1) begin
            vectors++;
            if (frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL stray_done: got frame_done=%0b without write, required 0", frame_done);
            end
        end
    end

    // Starts a frame and streams pixels; pushes expectations on every accept.
    task automatic drive_frame(input int valid_mode, input int last_pos, input int seed,
                               input int start_at, input int abort_at);
        int k;
        int cyc;
        sb_t e;
        logic v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_start: got s_ready=%0b busy=%0b, required 1 1", s_ready, busy);
        end
        exp_sync = 1'b0;
        k = 0;
        cyc = 0;
        while (k < NPIX && k != abort_at && cyc < 4 * NPIX) begin
            v       = (valid_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            start   = (cyc == start_at);
            s_valid = v;
            s_pixel = stim_pix(k, seed);
            s_last  = (k == last_pos);
            if (v && s_ready === 1'b1) begin
                if ((k == last_pos) != (k == NPIX - 1)) exp_sync = 1'b1;
                e.x    = AW'(k / IMG_W);
                e.y    = AW'(k % IMG_W);
                e.pix  = exp_pix(k, seed);
                e.done = (k == NPIX - 1);
                e.sync = exp_sync;
                sb_q.push_back(e);
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
        vectors++;
        if (k < NPIX && k != abort_at) begin
            miscompares++;
            $display("FAIL frame_timeout: got %0d accepts, required %0d", k, NPIX);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({s_ready, addr_x, addr_y, pixel_out, pixel_we, busy, frame_done, sync_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%0b x=%0d y=%0d pix=%0d we=%0b busy=%0b done=%0b err=%0b, required all 0",
                     s_ready, addr_x, addr_y, pixel_out, pixel_we, busy, frame_done, sync_err);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({s_ready, busy, pixel_we} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got rdy=%0b busy=%0b we=%0b, required 0 0 0", s_ready, busy, pixel_we);
        end
    endtask

    // Checks write count, empty scoreboard and busy dropping after DONE.
    task automatic frame_tail(input string name, input int w0, input logic err_exp);
        #1;
        vectors++;
        if (writes_seen - w0 !== NPIX || sb_q.size() != 0 || sync_err !== err_exp) begin
            miscompares++;
            $display("FAIL %s_tail: got writes=%0d pending=%0d err=%0b, required writes=%0d pending=0 err=%0b",
                     name, writes_seen - w0, sb_q.size(), sync_err, NPIX, err_exp);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy_drop: got busy=%0b rdy=%0b, required 0 0", name, busy, s_ready);
        end
    endtask

    task automatic test_basic();
        int w0 = writes_seen;
        drive_frame(0, NPIX - 1, 0, -1, -1);
        frame_tail("basic", w0, 1'b0);
    endtask

    task automatic test_valid_toggle();
        int w0 = writes_seen;
        @(negedge clk);
        drive_frame(1, NPIX - 1, 37, -1, -1);
        frame_tail("toggle", w0, 1'b0);
    endtask

    task automatic test_sync_err();
        int w0 = writes_seen;
        @(negedge clk);
        drive_frame(0, 10, 5, -1, -1);
        frame_tail("sync", w0, 1'b1);
    endtask

    task automatic test_start_ignored();
        int w0 = writes_seen;
        @(negedge clk);
        drive_frame(0, NPIX - 1, 77, 200, -1);
        start = 1'b1;
        frame_tail("start_ign", w0, 1'b0);
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_done_queued: got busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int w0;
        @(negedge clk);
        drive_frame(0, NPIX - 1, 11, -1, 150);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({s_ready, addr_x, addr_y, pixel_out, pixel_we, busy, frame_done, sync_err} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_values: got rdy=%0b x=%0d y=%0d pix=%0d we=%0b busy=%0b, required all 0",
                     s_ready, addr_x, addr_y, pixel_out, pixel_we, busy);
        end
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_reset_pending: got %0d pending writes, required 0", sb_q.size());
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        w0 = writes_seen;
        drive_frame(0, NPIX - 1, 3, -1, -1);
        frame_tail("restart", w0, 1'b0);
    endtask

`ifdef FRAME_PIXEL_SENDER_RGB_IN_EN
    task automatic test_rgb();
        int w0 = writes_seen;
        @(negedge clk);
        drive_frame(0, NPIX - 1, 99, -1, -1);
        frame_tail("rgb", w0, 1'b0);
    endtask
`endif

    initial begin
        clk     = 1'b0;
        reset_n = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_pixel = '0;
        s_last  = 1'b0;
        test_reset();
        test_basic();
        test_valid_toggle();
        test_sync_err();
        test_start_ignored();
        test_mid_reset();
`ifdef FRAME_PIXEL_SENDER_RGB_IN_EN
        test_rgb();
`endif
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_frame_pixel_sender
